// File: rtl/clock_ctrl.sv
// clock_ctrl: button-driven time/alarm edit sequencer, core time loader and alarm scheduler.
// Define CLOCK_CTRL_SNOOZE_EN to build in the snooze down-counter; otherwise snooze_pulse is ignored.
module clock_ctrl #(
    parameter int ALARM_LEN_MIN = 5,
    parameter int ALARM_RST_H   = 7,
    parameter int ALARM_RST_M   = 0,
    parameter int SNOOZE_MIN    = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode_pulse,
    input  logic                inc_pulse,
    input  logic                arm_pulse,
    input  logic                snooze_pulse,
    input  logic                minute_tick,
    input  logic [$clog2(60):0] cur_minutes,
    input  logic [$clog2(24):0] cur_hours,
    output logic                run_enable,
    output logic                set_load,
    output logic [$clog2(60):0] set_minutes,
    output logic [$clog2(24):0] set_hours,
    output logic [$clog2(60):0] alarm_minutes,
    output logic [$clog2(24):0] alarm_hours,
    output logic                alarm_armed,
    output logic                alarm_trigger,
    output logic [2:0]          mode
);
    localparam int MW = $clog2(60) + 1;
    localparam int HW = $clog2(24) + 1;
    localparam int RW = $clog2(ALARM_LEN_MIN + 1);
    localparam logic [HW-1:0] ALARM_H0  = HW'(ALARM_RST_H);
    localparam logic [MW-1:0] ALARM_M0  = MW'(ALARM_RST_M);
    localparam logic [RW-1:0] RING_LAST = RW'(ALARM_LEN_MIN - 1);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        T_HOUR = 3'd1,
        T_MIN  = 3'd2,
        A_HOUR = 3'd3,
        A_MIN  = 3'd4
    } state_e;

    function automatic logic [HW-1:0] hour_inc(input logic [HW-1:0] h);
        logic [HW-1:0] r;
        if (h >= 6'd23) r = 6'd0;
        else            r = h + 6'd1;
        return r;
    endfunction

    function automatic logic [MW-1:0] min_inc(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        if (m >= 7'd59) r = 7'd0;
        else            r = m + 7'd1;
        return r;
    endfunction

    state_e        state_r, state_s;
    logic [HW-1:0] edit_h_r, edit_h_s;
    logic [MW-1:0] edit_m_r, edit_m_s;
    logic [HW-1:0] alarm_h_r, set_h_r;
    logic [MW-1:0] alarm_m_r, set_m_r;
    logic          armed_r, trigger_r, trigger_s, match_d_r, set_load_r, run_en_r;
    logic [RW-1:0] ring_cnt_r, ring_cnt_s;
    logic          leave_run_s, ack_s, match_s, rise_s, load_s, store_s;

`ifdef CLOCK_CTRL_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_MIN + 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_MIN - 1);
    logic          snooze_act_r, snooze_act_s;
    logic [SW-1:0] snooze_cnt_r, snooze_cnt_s;
`else
    logic          unused_snooze_s;
    assign unused_snooze_s = snooze_pulse & (SNOOZE_MIN >= 1);
`endif

    assign leave_run_s = (state_r == RUN) && mode_pulse;
    assign ack_s       = (state_r == RUN) && inc_pulse && !mode_pulse;
    assign match_s     = (state_r == RUN) && armed_r &&
                         (cur_hours == alarm_h_r) && (cur_minutes == alarm_m_r);
    assign rise_s      = match_s && !match_d_r;
    assign load_s      = (state_r == T_MIN) && mode_pulse;
    assign store_s     = (state_r == A_MIN) && mode_pulse;

    // Mode sequencing: one step per mode_pulse, wrapping back to RUN.
    always_comb begin
        state_s = state_r;
        if (mode_pulse) begin
            case (state_r)
                RUN:     state_s = T_HOUR;
                T_HOUR:  state_s = T_MIN;
                T_MIN:   state_s = A_HOUR;
                A_HOUR:  state_s = A_MIN;
                A_MIN:   state_s = RUN;
                default: state_s = RUN;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Edit buffer: seeded on entry to the time and alarm pages, inc ignored when mode advances.
    always_comb begin
        edit_h_s = edit_h_r;
        edit_m_s = edit_m_r;
        if (mode_pulse) begin
            case (state_r)
                RUN: begin
                    edit_h_s = cur_hours;
                    edit_m_s = cur_minutes;
                end
                T_MIN: begin
                    edit_h_s = alarm_h_r;
                    edit_m_s = alarm_m_r;
                end
                default: edit_h_s = edit_h_r;
            endcase
        end else if (inc_pulse) begin
            case (state_r)
                T_HOUR, A_HOUR: edit_h_s = hour_inc(edit_h_r);
                T_MIN, A_MIN:   edit_m_s = min_inc(edit_m_r);
                default:        edit_h_s = edit_h_r;
            endcase
        end else begin
            edit_h_s = edit_h_r;
        end
    end

    // Ring control: hard clears first, then ringing, then pending snooze, then a new match edge.
    always_comb begin
        trigger_s  = trigger_r;
        ring_cnt_s = ring_cnt_r;
`ifdef CLOCK_CTRL_SNOOZE_EN
        snooze_act_s = snooze_act_r;
        snooze_cnt_s = snooze_cnt_r;
`endif
        if (arm_pulse || leave_run_s) begin
            trigger_s  = 1'b0;
            ring_cnt_s = {RW{1'b0}};
`ifdef CLOCK_CTRL_SNOOZE_EN
            snooze_act_s = 1'b0;
            snooze_cnt_s = {SW{1'b0}};
`endif
        end else if (trigger_r) begin
            if (ack_s) begin
                trigger_s  = 1'b0;
                ring_cnt_s = {RW{1'b0}};
`ifdef CLOCK_CTRL_SNOOZE_EN
            end else if (snooze_pulse) begin
                trigger_s    = 1'b0;
                ring_cnt_s   = {RW{1'b0}};
                snooze_act_s = 1'b1;
                snooze_cnt_s = {SW{1'b0}};
`endif
            end else if (minute_tick) begin
                if (ring_cnt_r == RING_LAST) begin
                    trigger_s  = 1'b0;
                    ring_cnt_s = {RW{1'b0}};
                end else begin
                    ring_cnt_s = ring_cnt_r + RW'(1);
                end
            end else begin
                ring_cnt_s = ring_cnt_r;
            end
`ifdef CLOCK_CTRL_SNOOZE_EN
        end else if (snooze_act_r) begin
            if (ack_s) begin
                snooze_act_s = 1'b0;
                snooze_cnt_s = {SW{1'b0}};
            end else if (minute_tick) begin
                if (snooze_cnt_r == SNOOZE_LAST) begin
                    snooze_act_s = 1'b0;
                    snooze_cnt_s = {SW{1'b0}};
                    trigger_s    = 1'b1;
                    ring_cnt_s   = {RW{1'b0}};
                end else begin
                    snooze_cnt_s = snooze_cnt_r + SW'(1);
                end
            end else begin
                snooze_cnt_s = snooze_cnt_r;
            end
`endif
        end else if (rise_s) begin
            trigger_s  = 1'b1;
            ring_cnt_s = {RW{1'b0}};
        end else begin
            trigger_s = trigger_r;
        end
    end

    // FSM, edit buffer and stored alarm time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= RUN;
            edit_h_r  <= 6'd0;
            edit_m_r  <= 7'd0;
            alarm_h_r <= ALARM_H0;
            alarm_m_r <= ALARM_M0;
            armed_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            edit_h_r <= edit_h_s;
            edit_m_r <= edit_m_s;
            armed_r  <= armed_r ^ arm_pulse;
            if (store_s) begin
                alarm_h_r <= edit_h_r;
                alarm_m_r <= edit_m_r;
            end else begin
                alarm_h_r <= alarm_h_r;
                alarm_m_r <= alarm_m_r;
            end
        end
    end

    // Alarm ring state and match edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trigger_r  <= 1'b0;
            ring_cnt_r <= {RW{1'b0}};
            match_d_r  <= 1'b0;
`ifdef CLOCK_CTRL_SNOOZE_EN
            snooze_act_r <= 1'b0;
            snooze_cnt_r <= {SW{1'b0}};
`endif
        end else begin
            trigger_r  <= trigger_s;
            ring_cnt_r <= ring_cnt_s;
            match_d_r  <= match_s;
`ifdef CLOCK_CTRL_SNOOZE_EN
            snooze_act_r <= snooze_act_s;
            snooze_cnt_r <= snooze_cnt_s;
`endif
        end
    end

    // Core-facing outputs; run_enable tracks the next state so it aligns with mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_en_r   <= 1'b1;
            set_load_r <= 1'b0;
            set_h_r    <= 6'd0;
            set_m_r    <= 7'd0;
        end else begin
            run_en_r   <= !((state_s == T_HOUR) || (state_s == T_MIN));
            set_load_r <= load_s;
            if (load_s) begin
                set_h_r <= edit_h_r;
                set_m_r <= edit_m_r;
            end else begin
                set_h_r <= set_h_r;
                set_m_r <= set_m_r;
            end
        end
    end

    assign run_enable    = run_en_r;
    assign set_load      = set_load_r;
    assign set_hours     = set_h_r;
    assign set_minutes   = set_m_r;
    assign alarm_hours   = alarm_h_r;
    assign alarm_minutes = alarm_m_r;
    assign alarm_armed   = armed_r;
    assign alarm_trigger = trigger_r;
    assign mode          = state_r;

endmodule
